// File: rtl/pokey_keyscan_core.sv
// pokey_keyscan_core
// Keyboard matrix scanner: walks a 6-bit scan address across the key matrix,
// samples the two return lines, debounces the first key it finds, and
// produces the key code, the modifier status and the keyboard/break IRQ pulses.
// All state moves on the falling clock edge, in step with the clock generator.

module pokey_keyscan_core #(
    parameter logic [5:0] SHIFT_ADDR = 6'h10,
    parameter logic [5:0] CTRL_ADDR  = 6'h20,
    parameter logic [5:0] BREAK_ADDR = 6'h30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enn,
    input  logic       keybClk,
    input  logic       scanEn,
    input  logic       debounceEn,
    input  logic       kr1_n,
    input  logic       kr2_n,
    output logic [5:0] keyAddr,
    output logic [7:0] kbcode,
    output logic       keyDown,
    output logic       shiftDown,
    output logic       keyIrq,
    output logic       brkIrq
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [5:0] key_addr_q, key_addr_d;
    logic [7:0] kbcode_q,   kbcode_d;
    logic       shift_q,    shift_d;
    logic       ctrl_q,     ctrl_d;
    logic       brk_q,      brk_d;
    logic       key_irq_q,  key_irq_d;
    logic       brk_irq_q,  brk_irq_d;
    logic [5:0] cand_q,     cand_d;
    logic [1:0] state_q,    state_d;

    logic step;
    logic press;
    logic hit;

    assign step  = enn & ~keybClk;
    assign press = ~kr1_n;
    assign hit   = (key_addr_q == cand_q);

    // Next-state logic: scan address, modifier sampling and the debounce machine.
    always_comb begin
        key_addr_d = key_addr_q;
        kbcode_d   = kbcode_q;
        shift_d    = shift_q;
        ctrl_d     = ctrl_q;
        brk_d      = brk_q;
        cand_d     = cand_q;
        state_d    = state_q;
        key_irq_d  = 1'b0;
        brk_irq_d  = 1'b0;

        if (!scanEn) begin
            key_addr_d = 6'h00;
            shift_d    = 1'b0;
            ctrl_d     = 1'b0;
            brk_d      = 1'b0;
            cand_d     = 6'h00;
            state_d    = ST_IDLE;
        end else if (step) begin
            key_addr_d = key_addr_q + 6'd1;

            if (key_addr_q == SHIFT_ADDR) begin
                shift_d = ~kr2_n;
            end
            if (key_addr_q == CTRL_ADDR) begin
                ctrl_d = ~kr2_n;
            end
            if (key_addr_q == BREAK_ADDR) begin
                brk_d     = ~kr2_n;
                brk_irq_d = ~brk_q & ~kr2_n;
            end

            case (state_q)
                ST_IDLE: begin
                    if (press) begin
                        cand_d = key_addr_q;
                        if (debounceEn) begin
                            state_d = ST_CONFIRM;
                        end else begin
                            kbcode_d  = {ctrl_q, shift_q, key_addr_q};
                            key_irq_d = 1'b1;
                            state_d   = ST_HELD;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (hit) begin
                        if (press) begin
                            kbcode_d  = {ctrl_q, shift_q, cand_q};
                            key_irq_d = 1'b1;
                            state_d   = ST_HELD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_HELD: begin
                    if (hit && !press) begin
                        state_d = debounceEn ? ST_RELEASE : ST_IDLE;
                    end
                end
                ST_RELEASE: begin
                    if (hit) begin
                        state_d = press ? ST_HELD : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset; reset also clears the key code.
    always_ff @(negedge clk) begin
        if (reset) begin
            key_addr_q <= 6'h00;
            kbcode_q   <= 8'h00;
            shift_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            brk_q      <= 1'b0;
            key_irq_q  <= 1'b0;
            brk_irq_q  <= 1'b0;
            cand_q     <= 6'h00;
            state_q    <= ST_IDLE;
        end else begin
            key_addr_q <= key_addr_d;
            kbcode_q   <= kbcode_d;
            shift_q    <= shift_d;
            ctrl_q     <= ctrl_d;
            brk_q      <= brk_d;
            key_irq_q  <= key_irq_d;
            brk_irq_q  <= brk_irq_d;
            cand_q     <= cand_d;
            state_q    <= state_d;
        end
    end

    assign keyAddr   = key_addr_q;
    assign kbcode    = kbcode_q;
    assign keyDown   = (state_q == ST_HELD) || (state_q == ST_RELEASE);
    assign shiftDown = shift_q;
    assign keyIrq    = key_irq_q;
    assign brkIrq    = brk_irq_q;

endmodule
